// File: rtl/ahb_arbiter_if.sv
// Bus-side signal bundle for ahb_arbiter; the slave modport is the arbiter's view.
// HLOCK exists only when AHB_ARB_LOCK_EN is defined.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
) ();
  localparam int MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
`ifdef AHB_ARB_LOCK_EN
  logic [NUM_MASTERS-1:0] HLOCK;
`endif
  logic [1:0]             HTRANS;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic [MW-1:0]          HMASTER_DATA;
  logic                   HMASTLOCK;

`ifdef AHB_ARB_LOCK_EN
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HREADY,
    output HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK
  );
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HREADY,
    input  HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK
  );
`else
  modport slave (
    input  HBUSREQ, HTRANS, HREADY,
    output HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK
  );
  modport master (
    output HBUSREQ, HTRANS, HREADY,
    input  HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK
  );
`endif
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: registered one-hot grant, address/data owner pipeline, beat-limited tenure.
// Optional locked transfers with AHB_ARB_LOCK_EN; everything advances only on HREADY=1 edges.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_BEATS      = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  ahb_arbiter_if.slave bus
);
  localparam int MW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef logic [MW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  localparam idx_t DEF_IDX = idx_t'(DEFAULT_MASTER);
  localparam cnt_t MAX_CNT = cnt_t'(MAX_BEATS);

  idx_t r_owner;
  idx_t r_hmaster;
  idx_t r_hmaster_data;
  cnt_t r_beat_cnt;

  idx_t                   w_next_owner;
  cnt_t                   w_next_cnt;
  idx_t                   w_rr_idx;
  logic                   w_rr_found;
  logic                   w_keep;
  logic                   w_lock_hold;
  logic                   w_cnt_clr;
  logic                   w_beat;
  logic [NUM_MASTERS-1:0] w_grant;

`ifdef AHB_ARB_LOCK_EN
  logic r_hmastlock;

  always_comb begin
    w_lock_hold = r_hmastlock & bus.HLOCK[r_owner];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hmastlock <= 1'b0;
    end else if (bus.HREADY) begin
      r_hmastlock <= bus.HLOCK[r_owner];
    end
  end

  assign bus.HMASTLOCK = r_hmastlock;
`else
  always_comb begin
    w_lock_hold = 1'b0;
  end

  assign bus.HMASTLOCK = 1'b0;
`endif

  // Search starts just after the owner and reaches the owner itself last.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_owner;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      int cand;
      cand = (int'(r_owner) + i) % NUM_MASTERS;
      if (!w_rr_found && bus.HBUSREQ[cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = idx_t'(cand);
      end
    end
  end

  always_comb begin
    w_beat       = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);
    w_keep       = w_lock_hold || (bus.HBUSREQ[r_owner] && (r_beat_cnt < MAX_CNT));
    w_next_owner = r_owner;
    w_cnt_clr    = 1'b0;
    if (!w_keep) begin
      if (w_rr_found) begin
        w_next_owner = w_rr_idx;
        w_cnt_clr    = 1'b1;
      end else begin
        w_next_owner = DEF_IDX;
        w_cnt_clr    = (DEF_IDX != r_owner);
      end
    end
    w_next_cnt = r_beat_cnt;
    if (w_cnt_clr) begin
      w_next_cnt = '0;
    end else if (w_beat && (r_beat_cnt < MAX_CNT)) begin
      w_next_cnt = r_beat_cnt + cnt_t'(1);
    end
  end

  // Grant, address owner and data owner shift together so no stage can slip.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_owner        <= DEF_IDX;
      r_beat_cnt     <= '0;
      r_hmaster      <= DEF_IDX;
      r_hmaster_data <= DEF_IDX;
    end else if (bus.HREADY) begin
      r_owner        <= w_next_owner;
      r_beat_cnt     <= w_next_cnt;
      r_hmaster      <= r_owner;
      r_hmaster_data <= r_hmaster;
    end
  end

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_grant[i] = (r_owner == idx_t'(i));
    end
  end

  assign bus.HGRANT       = w_grant;
  assign bus.HMASTER      = r_hmaster;
  assign bus.HMASTER_DATA = r_hmaster_data;
endmodule
